// File: rtl/kilit_giris_denetleyici_pkg.sv
// Shared types for the dual-lock step-entry controller.
// State encoding and step-slot widths.
package kilit_giris_denetleyici_pkg;

  localparam int SAG_W = 3;
  localparam int SOL_W = 2;

  localparam logic [2:0] S_SAG1    = 3'd0;
  localparam logic [2:0] S_SOL1    = 3'd1;
  localparam logic [2:0] S_SAG2    = 3'd2;
  localparam logic [2:0] S_SOL2    = 3'd3;
  localparam logic [2:0] S_KONTROL = 3'd4;
  localparam logic [2:0] S_ACIK    = 3'd5;
  localparam logic [2:0] S_KILITLI = 3'd6;

  typedef enum logic [2:0] {
    SAG1    = S_SAG1,
    SOL1    = S_SOL1,
    SAG2    = S_SAG2,
    SOL2    = S_SOL2,
    KONTROL = S_KONTROL,
    ACIK    = S_ACIK,
    KILITLI = S_KILITLI
  } durum_t;

endpackage

// File: rtl/kilit_giris_denetleyici_bekleme_sayaci.sv
// Lockout wait counter: load, count down to zero, flag last cycle.
// bitti is high in the final cycle of the wait.
module bekleme_sayaci (
  input  logic       clk,
  input  logic       rst,
  input  logic       yukle,
  input  logic [7:0] yukle_deger,
  input  logic       azalt,
  output logic       bitti
);

  logic [7:0] sayac_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sayac_q <= '0;
    end else if (yukle) begin
      sayac_q <= yukle_deger;
    end else if (azalt && sayac_q != 8'd0) begin
      sayac_q <= sayac_q - 8'd1;
    end
  end

  // The decrement that lands on zero is the last lockout cycle.
  assign bitti = (sayac_q <= 8'd1);

endmodule

// File: rtl/kilit_giris_denetleyici.sv
// Step-entry controller for a dual combination lock with
// failed-attempt counting and timed lockout.
module kilit_giris_denetleyici
  import kilit_giris_denetleyici_pkg::*;
#(
  parameter int MAX_HATA       = 3,
  parameter int BEKLEME_CEVRIM = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] deger,
  input  logic       gir,
  input  logic       iptal,
  input  logic       kilitler_acik,
  output logic [5:0] sag_adimlar,
  output logic [3:0] sol_adimlar,
  output logic       kontrol,
  output logic       acik,
  output logic       kilitli,
  output logic [1:0] hata_sayisi
);

  localparam logic [2:0] MAX_3 = 3'(MAX_HATA);
  localparam logic [1:0] MAX_2 = 2'(MAX_HATA);
  localparam logic [7:0] BEKLE = 8'(BEKLEME_CEVRIM);

  durum_t     durum_q, durum_n;
  logic [5:0] sag_q, sag_n;
  logic [3:0] sol_q, sol_n;
  logic [1:0] hata_q, hata_n;
  logic       acik_q;
  logic       yukle, azalt, bitti;
  logic [2:0] hata_art;

  assign hata_art = {1'b0, hata_q} + 3'd1;

  bekleme_sayaci u_sayac (
    .clk         (clk),
    .rst         (rst),
    .yukle       (yukle),
    .yukle_deger (BEKLE),
    .azalt       (azalt),
    .bitti       (bitti)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      durum_q <= SAG1;
      sag_q   <= '0;
      sol_q   <= '0;
      hata_q  <= '0;
      acik_q  <= 1'b0;
    end else begin
      durum_q <= durum_n;
      sag_q   <= sag_n;
      sol_q   <= sol_n;
      hata_q  <= hata_n;
      acik_q  <= (durum_n == ACIK);
    end
  end

  always_comb begin
    durum_n = durum_q;
    sag_n   = sag_q;
    sol_n   = sol_q;
    hata_n  = hata_q;
    yukle   = 1'b0;
    azalt   = 1'b0;
    unique case (durum_q)
      SAG1, SOL1, SAG2, SOL2: begin
        if (iptal) begin
          durum_n = SAG1;
          sag_n   = '0;
          sol_n   = '0;
        end else if (gir) begin
          unique case (durum_q)
            SAG1: begin
              sag_n[5:3] = deger;
              durum_n    = SOL1;
            end
            SOL1: begin
              sol_n[3:2] = deger[1:0];
              durum_n    = SAG2;
            end
            SAG2: begin
              sag_n[2:0] = deger;
              durum_n    = SOL2;
            end
            default: begin
              sol_n[1:0] = deger[1:0];
              durum_n    = KONTROL;
            end
          endcase
        end
      end
      KONTROL: begin
        sag_n = '0;
        sol_n = '0;
        if (kilitler_acik) begin
          durum_n = ACIK;
          hata_n  = '0;
        end else if (hata_art < MAX_3) begin
          durum_n = SAG1;
          hata_n  = hata_art[1:0];
        end else begin
          durum_n = KILITLI;
          hata_n  = MAX_2;
          yukle   = 1'b1;
        end
      end
      ACIK: begin
        if (iptal) durum_n = SAG1;
      end
      KILITLI: begin
        azalt = 1'b1;
        if (bitti) begin
          durum_n = SAG1;
          hata_n  = '0;
        end
      end
      default: durum_n = SAG1;
    endcase
  end

  assign sag_adimlar = sag_q;
  assign sol_adimlar = sol_q;
  assign hata_sayisi = hata_q;
  assign acik        = acik_q;
  assign kontrol     = (durum_q == KONTROL);
  assign kilitli     = (durum_q == KILITLI);

endmodule

// File: tb/tb_kilit_giris_denetleyici.sv
// Self-checking bench for kilit_giris_denetleyici: entry table,
// kontrol-cycle scoreboard, lockout, cancel and reset sequences.
module tb_kilit_giris_denetleyici;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] deger = '0;
  logic       gir = 1'b0;
  logic       iptal = 1'b0;
  logic       kilitler_acik = 1'b0;
  logic [5:0] sag_adimlar;
  logic [3:0] sol_adimlar;
  logic       kontrol, acik, kilitli;
  logic [1:0] hata_sayisi;

  int toplam = 0;
  int gecen = 0;

  typedef struct {
    logic [2:0] d0, d1, d2, d3;
    logic       ok;
    logic [5:0] sag;
    logic [3:0] sol;
    logic       acik;
    logic [1:0] hata;
    logic       kilitli;
  } vec_t;

  typedef struct {
    logic [5:0] sag;
    logic [3:0] sol;
  } sb_t;

  sb_t  sb[$];
  vec_t tablo[4];

  kilit_giris_denetleyici #(.MAX_HATA(3), .BEKLEME_CEVRIM(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .deger         (deger),
    .gir           (gir),
    .iptal         (iptal),
    .kilitler_acik (kilitler_acik),
    .sag_adimlar   (sag_adimlar),
    .sol_adimlar   (sol_adimlar),
    .kontrol       (kontrol),
    .acik          (acik),
    .kilitli       (kilitli),
    .hata_sayisi   (hata_sayisi)
  );

  always #5 clk = ~clk;

  task automatic chk(input string ad, input logic [7:0] got,
                     input logic [7:0] exp);
    toplam++;
    if (got === exp) gecen++;
    else $display("FAIL %s: got=%0h exp=%0h t=%0t", ad, got, exp, $time);
  endtask

  // Scoreboard: step registers must match the entry in the kontrol cycle.
  always @(negedge clk) begin
    if (!rst && kontrol) begin
      if (sb.size() == 0) begin
        chk("kontrol_beklenmedik", {7'd0, kontrol}, 8'd0);
      end else begin
        sb_t e;
        e = sb.pop_front();
        chk("sb_sag", {2'd0, sag_adimlar}, {2'd0, e.sag});
        chk("sb_sol", {4'd0, sol_adimlar}, {4'd0, e.sol});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gir_step(input logic [2:0] d);
    deger = d;
    gir = 1'b1;
    tick();
    gir = 1'b0;
  endtask

  task automatic apply(input vec_t v);
    sb_t e;
    kilitler_acik = v.ok;
    e.sag = v.sag;
    e.sol = v.sol;
    sb.push_back(e);
    gir_step(v.d0);
    gir_step(v.d1);
    gir_step(v.d2);
    gir_step(v.d3);
    chk("kontrol_1", {7'd0, kontrol}, 8'd1);
    tick();
    kilitler_acik = 1'b0;
    chk("kontrol_0", {7'd0, kontrol}, 8'd0);
    chk("acik", {7'd0, acik}, {7'd0, v.acik});
    chk("hata", {6'd0, hata_sayisi}, {6'd0, v.hata});
    chk("sag_sifir", {2'd0, sag_adimlar}, 8'd0);
    chk("sol_sifir", {4'd0, sol_adimlar}, 8'd0);
    chk("kilitli", {7'd0, kilitli}, {7'd0, v.kilitli});
  endtask

  task automatic fail_entry(input logic [1:0] h, input logic k);
    vec_t v;
    v = '{3'd5, 3'd3, 3'd2, 3'd1, 1'b0, 6'b101010, 4'b1101, 1'b0, h, k};
    apply(v);
  endtask

  task automatic iptal_acik();
    iptal = 1'b1;
    tick();
    iptal = 1'b0;
    chk("iptal_acik", {7'd0, acik}, 8'd0);
  endtask

  initial begin
    int n;
    tablo[0] = '{3'd5, 3'd3, 3'd2, 3'd1, 1'b1, 6'b101010, 4'b1101,
                 1'b1, 2'd0, 1'b0};
    tablo[1] = '{3'd5, 3'd3, 3'd2, 3'd1, 1'b0, 6'b101010, 4'b1101,
                 1'b0, 2'd1, 1'b0};
    tablo[2] = '{3'd7, 3'd7, 3'd6, 3'd6, 1'b0, 6'b111110, 4'b1110,
                 1'b0, 2'd2, 1'b0};
    tablo[3] = '{3'd0, 3'd1, 3'd4, 3'd0, 1'b1, 6'b000100, 4'b0100,
                 1'b1, 2'd0, 1'b0};

    #3;
    chk("rst_sag", {2'd0, sag_adimlar}, 8'd0);
    chk("rst_kontrol", {7'd0, kontrol}, 8'd0);
    chk("rst_acik", {7'd0, acik}, 8'd0);
    chk("rst_kilitli", {7'd0, kilitli}, 8'd0);
    chk("rst_hata", {6'd0, hata_sayisi}, 8'd0);
    tick();
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      apply(tablo[i]);
      if (tablo[i].acik) begin
        gir_step(3'd4);
        chk("acik_gir_yok", {2'd0, sag_adimlar}, 8'd0);
        iptal_acik();
      end
    end

    // Held entry without gir
    gir_step(3'd6);
    repeat (3) tick();
    chk("tut_sag", {2'd0, sag_adimlar}, 8'h30);
    chk("tut_kontrol", {7'd0, kontrol}, 8'd0);
    iptal = 1'b1;
    tick();
    iptal = 1'b0;

    // Lockout after three failures
    fail_entry(2'd1, 1'b0);
    fail_entry(2'd2, 1'b0);
    fail_entry(2'd3, 1'b1);
    n = 0;
    deger = 3'd7;
    for (int c = 0; c < 100 && kilitli; c++) begin
      n++;
      gir = 1'b1;
      iptal = c[0];
      tick();
    end
    gir = 1'b0;
    iptal = 1'b0;
    chk("kilit_sure", 8'(n), 8'd16);
    chk("kilit_son_hata", {6'd0, hata_sayisi}, 8'd0);
    chk("kilit_son_sag", {2'd0, sag_adimlar}, 8'd0);
    chk("kilit_son_kontrol", {7'd0, kontrol}, 8'd0);

    // Cancel with simultaneous gir keeps the failure count
    fail_entry(2'd1, 1'b0);
    gir_step(3'd5);
    gir_step(3'd3);
    deger = 3'd4;
    gir = 1'b1;
    iptal = 1'b1;
    tick();
    gir = 1'b0;
    iptal = 1'b0;
    chk("iptal_sag", {2'd0, sag_adimlar}, 8'd0);
    chk("iptal_sol", {4'd0, sol_adimlar}, 8'd0);
    chk("iptal_hata", {6'd0, hata_sayisi}, 8'd1);
    apply(tablo[0]);
    iptal_acik();

    // Reset mid-lockout
    fail_entry(2'd1, 1'b0);
    fail_entry(2'd2, 1'b0);
    fail_entry(2'd3, 1'b1);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    chk("rstk_kilitli", {7'd0, kilitli}, 8'd0);
    chk("rstk_hata", {6'd0, hata_sayisi}, 8'd0);
    tick();
    rst = 1'b0;

    // Reset in SOL2
    gir_step(3'd5);
    gir_step(3'd3);
    gir_step(3'd2);
    #2 rst = 1'b1;
    #1;
    chk("rsts_sag", {2'd0, sag_adimlar}, 8'd0);
    chk("rsts_sol", {4'd0, sol_adimlar}, 8'd0);
    chk("rsts_kontrol", {7'd0, kontrol}, 8'd0);
    tick();
    rst = 1'b0;
    apply(tablo[0]);
    iptal_acik();

    chk("sb_kalan", 8'(sb.size()), 8'd0);
    $display("%0d/%0d checks passed", gecen, toplam);
    $finish;
  end

endmodule

// File: doc/kilit_giris_denetleyici.md
KILIT_GIRIS_DENETLEYICI -- requirements
Module: kilit_giris_denetleyici

Interface
REQ-001 Parameter MAX_HATA, default 3, consecutive failed attempts that trigger lockout (range 1..3).
REQ-002 Parameter BEKLEME_CEVRIM, default 16, lockout duration in clock cycles (range 1..255).
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 deger  input  3  step value being entered; only bits [1:0] are used in left-step states.
REQ-006 gir  input  1  one-cycle strobe that captures deger into the current step slot.
REQ-007 iptal  input  1  cancel the entry in progress, or relock when open.
REQ-008 kilitler_acik  input  1  combinational result from the downstream dual-lock checker.
REQ-009 sag_adimlar  output  6  captured right steps: [5:3] lock 1, [2:0] lock 2.
REQ-010 sol_adimlar  output  4  captured left steps: [3:2] lock 1, [1:0] lock 2.
REQ-011 kontrol  output  1  one-cycle pulse; kilitler_acik is sampled in this cycle.
REQ-012 acik  output  1  high while both locks are open.
REQ-013 kilitli  output  1  high during lockout.
REQ-014 hata_sayisi  output  2  count of consecutive failed attempts.

Function
REQ-015 FSM states: SAG1, SOL1, SAG2, SOL2, KONTROL, ACIK, KILITLI.
REQ-016 Entry order on gir:
- SAG1 -> SOL1 captures deger into sag_adimlar[5:3].
- SOL1 -> SAG2 captures deger[1:0] into sol_adimlar[3:2].
- SAG2 -> SOL2 captures deger into sag_adimlar[2:0].
- SOL2 -> KONTROL captures deger[1:0] into sol_adimlar[1:0].
REQ-017 In entry states without gir, the FSM and the step registers hold.
REQ-018 KONTROL lasts exactly 1 cycle; kontrol=1 only in this state, 1 cycle after the 4th gir.
REQ-019 KONTROL outcome:
- kilitler_acik=1: go to ACIK and clear hata_sayisi.
- kilitler_acik=0 and hata_sayisi+1 < MAX_HATA: go to SAG1 and increment hata_sayisi.
- kilitler_acik=0 and hata_sayisi+1 >= MAX_HATA: go to KILITLI, set hata_sayisi to MAX_HATA, load the wait counter with BEKLEME_CEVRIM.
REQ-020 The step registers clear to 0 on every exit from KONTROL.
REQ-021 acik is a registered output, =1 exactly while in ACIK.
REQ-022 In ACIK: gir is ignored; iptal returns to SAG1.
REQ-023 In KILITLI:
- kilitli=1.
- The counter decrements each cycle; gir and iptal are ignored.
- When the counter reaches 0, go to SAG1 and clear hata_sayisi.
- Total lockout is BEKLEME_CEVRIM cycles.
REQ-024 iptal in any entry state (SAG1..SOL2): go to SAG1, clear the step registers, leave hata_sayisi unchanged.
REQ-025 gir and iptal in the same cycle: iptal wins.
REQ-026 The wait counter is 8 bits; hata_sayisi saturates and never wraps.

Reset
REQ-027 rst=1 asynchronously forces SAG1, clears the step registers, counter and hata_sayisi, and drives kontrol=0, acik=0, kilitli=0.
REQ-028 Reset asserted mid-entry, in ACIK, or in KILITLI discards all progress; the first gir after release is taken as the lock-1 right step.

Structure
REQ-029 A shared package holds the state encoding (3-bit localparams) and the step-slot widths (3 and 2).
REQ-030 One sub-module, bekleme_sayaci (load, decrement-to-zero, done flag), implements the lockout counter.
REQ-031 The block connects port-for-port to the downstream dual-lock checker's step inputs and open output.

Verification
REQ-032 Valid entry: gir with deger 5,3,2,1, kilitler_acik=1 at kontrol -> sag_adimlar=6'b101010, sol_adimlar=4'b1101, kontrol pulse 1 cycle after the 4th gir, then acik=1 and hata_sayisi=0.
REQ-033 Bad entry: same sequence with kilitler_acik=0 -> state SAG1, registers 0, hata_sayisi=1, acik=0.
REQ-034 Lockout: 3 failed attempts -> kilitli=1 for exactly 16 cycles, gir ignored throughout, then SAG1 with hata_sayisi=0.
REQ-035 Cancel: iptal with gir after 2 entries -> SAG1, registers 0, hata_sayisi unchanged; in ACIK, iptal -> acik=0.
REQ-036 Reset: rst pulsed mid-lockout and in SOL2 -> all outputs 0 immediately (asynchronous); a fresh entry then succeeds.
